// File: rtl/ethernet_fmc_trace_pkg.sv
// Shared types and constants for the Ethernet FMC trace streaming path.
package ethernet_fmc_trace_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        READ,
        DRAIN,
        DONE
    } streamState_e;

    localparam int TRACE_ROW_BYTES = 32;
    localparam int HALF_BYTES      = 16;
    localparam int ROW_SHIFT       = $clog2(TRACE_ROW_BYTES);
    localparam int HALF_SHIFT      = $clog2(HALF_BYTES);

    localparam int HDR_FIELD_W   = 16;
    localparam int HDR_MAGIC_LSB = 0;
    localparam int HDR_FIRST_LSB = 16;
    localparam int HDR_COUNT_LSB = 32;

    localparam logic [15:0] MAGIC_DEFAULT = 16'h7E5C;

endpackage

// File: rtl/trace_stream_fifo2.sv
// Two-entry data+last FIFO with simultaneous push/pop and a synchronous flush.
// The head always lives in slot 0 so the stream outputs come straight from a register.
module trace_stream_fifo2 #(
    parameter int DATA_W = 128
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] pushData_i,
    input  logic              pushLast_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] headData_o,
    output logic              headLast_o,
    output logic              valid_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic              last0_q, last0_d, last1_q, last1_d;
    logic [1:0]        count_q, count_d;
    logic              doPush, doPop;

    always_comb begin
        doPop   = pop_i && (count_q != 2'd0);
        doPush  = push_i && ((count_q != 2'd2) || doPop);
        data0_d = data0_q;
        last0_d = last0_q;
        data1_d = data1_q;
        last1_d = last1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({doPush, doPop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        data0_d = pushData_i;
                        last0_d = pushLast_i;
                    end else begin
                        data1_d = pushData_i;
                        last1_d = pushLast_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // With one entry the incoming beat replaces the departing head directly.
                    if (count_q == 2'd2) begin
                        data0_d = data1_q;
                        last0_d = last1_q;
                        data1_d = pushData_i;
                        last1_d = pushLast_i;
                    end else begin
                        data0_d = pushData_i;
                        last0_d = pushLast_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data0_q <= '0;
            last0_q <= 1'b0;
            data1_q <= '0;
            last1_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            data0_q <= data0_d;
            last0_q <= last0_d;
            data1_q <= data1_d;
            last1_q <= last1_d;
            count_q <= count_d;
        end
    end

    assign headData_o = data0_q;
    assign headLast_o = last0_q;
    assign valid_o    = (count_q != 2'd0);
    assign count_o    = count_q;

endmodule

// File: rtl/ethernet_fmc_trace_streamer.sv
// Dumps the valid rows of the instruction-trace ring oldest-first as a 128-bit
// valid/ready stream: one header beat, then two half-row beats per row, tlast on the final beat.
module ethernet_fmc_trace_streamer
    import ethernet_fmc_trace_pkg::*;
#(
    parameter logic [31:0] TRACE_BASEADDR = 32'h0010_0000,
    parameter int          TRACE_DEPTH    = 1024,
    parameter int          MEM_DATA_SIZE  = 128,
    parameter int          MEM_ADDR_SIZE  = 32,
    parameter logic [15:0] MAGIC          = MAGIC_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [MEM_ADDR_SIZE-1:0] trace_ptr_i,
    input  logic [MEM_ADDR_SIZE-1:0] trace_count_i,
    output logic                     trace_mem_en_o,
    output logic [MEM_ADDR_SIZE-1:0] trace_mem_addr_o,
    input  logic [MEM_DATA_SIZE-1:0] trace_mem_rdata_i,
    output logic [MEM_DATA_SIZE-1:0] m_tdata_o,
    output logic                     m_tvalid_o,
    output logic                     m_tlast_o,
    input  logic                     m_tready_i,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int ROW_W = $clog2(TRACE_DEPTH);
    localparam int IDX_W = ROW_W + 2;
    localparam logic [MEM_ADDR_SIZE-1:0] DEPTH_A = MEM_ADDR_SIZE'(TRACE_DEPTH);
    localparam logic [ROW_W:0]           DEPTH_N = (ROW_W + 1)'(TRACE_DEPTH);
    localparam logic [MEM_ADDR_SIZE-1:0] BASE_A  = MEM_ADDR_SIZE'(TRACE_BASEADDR);

    streamState_e state_q;
    logic [ROW_W:0]     nRows_q, nSnap;
    logic [ROW_W-1:0]   firstRow_q, firstSnap, rowIdx;
    logic [IDX_W-1:0]   readIdx_q, totalReads;
    logic               inflight_q, inflightLast_q;
    logic [1:0]         fifoCount;
    logic               fifoValid;
    logic               pop, issue, lastRead, pushHdr, push, pushLast, flush, drainDone, active;
    logic [2:0]         occAfterPop;
    logic [MEM_DATA_SIZE-1:0] hdrBeat, pushData;
    logic [ROW_W+ROW_SHIFT-1:0] rowOffset;
    logic               unusedPtrBits;

    assign unusedPtrBits = ^trace_ptr_i[MEM_ADDR_SIZE-1:ROW_W];

    always_comb begin
        nSnap     = (trace_count_i > DEPTH_A) ? DEPTH_N : trace_count_i[ROW_W:0];
        firstSnap = trace_ptr_i[ROW_W-1:0] - nSnap[ROW_W-1:0];

        active      = (state_q == HDR) || (state_q == READ) || (state_q == DRAIN);
        flush       = active && abort_i;
        pop         = fifoValid && m_tready_i;
        // Reads still in flight already own a FIFO slot, so they count as occupancy.
        occAfterPop = 3'(fifoCount) - 3'(pop) + 3'(inflight_q);
        totalReads  = {nRows_q, 1'b0};
        lastRead    = (readIdx_q == totalReads - IDX_W'(1));
        issue       = (state_q == READ) && !abort_i && (occAfterPop < 3'd2);
        drainDone   = !inflight_q && ((fifoCount == 2'd0) || ((fifoCount == 2'd1) && pop));

        rowIdx    = firstRow_q + readIdx_q[ROW_W:1];
        rowOffset = {rowIdx, readIdx_q[0], {HALF_SHIFT{1'b0}}};

        hdrBeat = '0;
        hdrBeat[HDR_MAGIC_LSB +: HDR_FIELD_W] = MAGIC;
        hdrBeat[HDR_FIRST_LSB +: HDR_FIELD_W] = HDR_FIELD_W'(firstRow_q);
        hdrBeat[HDR_COUNT_LSB +: HDR_FIELD_W] = HDR_FIELD_W'(nRows_q);

        pushHdr  = (state_q == HDR) && !abort_i;
        push     = pushHdr || inflight_q;
        pushData = pushHdr ? hdrBeat : trace_mem_rdata_i;
        pushLast = pushHdr ? (nRows_q == '0) : inflightLast_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= IDLE;
            nRows_q        <= '0;
            firstRow_q     <= '0;
            readIdx_q      <= '0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
        end else begin
            inflight_q     <= issue;
            inflightLast_q <= issue && lastRead;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        nRows_q    <= nSnap;
                        firstRow_q <= firstSnap;
                        readIdx_q  <= '0;
                        state_q    <= HDR;
                    end
                end
                HDR: begin
                    if (abort_i)               state_q <= DONE;
                    else if (nRows_q == '0)    state_q <= DRAIN;
                    else                       state_q <= READ;
                end
                READ: begin
                    if (abort_i) begin
                        state_q <= DONE;
                    end else if (issue) begin
                        readIdx_q <= readIdx_q + IDX_W'(1);
                        if (lastRead) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort_i || drainDone) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    trace_stream_fifo2 #(
        .DATA_W (MEM_DATA_SIZE)
    ) u_fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .flush_i    (flush),
        .push_i     (push),
        .pushData_i (pushData),
        .pushLast_i (pushLast),
        .pop_i      (pop),
        .headData_o (m_tdata_o),
        .headLast_o (m_tlast_o),
        .valid_o    (fifoValid),
        .count_o    (fifoCount)
    );

    assign m_tvalid_o       = fifoValid;
    assign trace_mem_en_o   = issue;
    assign trace_mem_addr_o = issue ? (BASE_A + MEM_ADDR_SIZE'(rowOffset)) : '0;
    assign busy_o           = active;
    assign done_o           = (state_q == DONE);

endmodule

// File: tb/tb_ethernet_fmc_trace_streamer.sv
// Randomized bench for the trace streamer: a row-level model of the ring builds the
// expected beat and address sequences, and a monitor records what the DUT actually emits.
module tb_ethernet_fmc_trace_streamer;

    localparam logic [31:0] BASE  = 32'h0010_0000;
    localparam int          DEPTH = 1024;
    localparam logic [15:0] MAGIC = 16'h7E5C;

    logic         clk_i = 1'b0;
    logic         reset_n_i = 1'b0;
    logic         start_i = 1'b0;
    logic         abort_i = 1'b0;
    logic [31:0]  trace_ptr_i = '0;
    logic [31:0]  trace_count_i = '0;
    logic         trace_mem_en_o;
    logic [31:0]  trace_mem_addr_o;
    logic [127:0] trace_mem_rdata_i = '0;
    logic [127:0] m_tdata_o;
    logic         m_tvalid_o;
    logic         m_tlast_o;
    logic         m_tready_i = 1'b1;
    logic         busy_o;
    logic         done_o;

    int checks = 0;
    int errors = 0;
    bit readyRandom = 1'b0;
    bit monOn = 1'b0;

    logic [127:0] gotData[$];
    bit           gotLast[$];
    logic [31:0]  gotAddr[$];
    logic [127:0] expData[$];
    bit           expLast[$];
    logic [31:0]  expAddr[$];
    int issued, xfers, cycle, lastXferCycle, doneSeen, firstDoneCycle;

    typedef struct {
        logic [31:0] ptr;
        logic [31:0] cnt;
        bit          rnd;
    } scen_t;

    ethernet_fmc_trace_streamer dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .start_i           (start_i),
        .abort_i           (abort_i),
        .trace_ptr_i       (trace_ptr_i),
        .trace_count_i     (trace_count_i),
        .trace_mem_en_o    (trace_mem_en_o),
        .trace_mem_addr_o  (trace_mem_addr_o),
        .trace_mem_rdata_i (trace_mem_rdata_i),
        .m_tdata_o         (m_tdata_o),
        .m_tvalid_o        (m_tvalid_o),
        .m_tlast_o         (m_tlast_o),
        .m_tready_i        (m_tready_i),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [127:0] memWord(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a * 32'd3, ~a, a + 32'h1234_5678};
    endfunction

    // Synchronous read port: data valid exactly one cycle after en, junk otherwise.
    always @(posedge clk_i) begin
        if (trace_mem_en_o) trace_mem_rdata_i <= memWord(trace_mem_addr_o);
        else                trace_mem_rdata_i <= {$urandom, $urandom, $urandom, $urandom};
    end

    always @(posedge clk_i) begin
        #1;
        m_tready_i = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Header plus every issued read either sits in the buffer, is in flight, or was delivered.
    always @(negedge clk_i) begin
        cycle++;
        if (monOn) begin
            if (trace_mem_en_o) begin
                checks++;
                if (1 + issued - xfers - ((m_tvalid_o && m_tready_i) ? 1 : 0) >= 2) begin
                    errors++;
                    $display("[TB] FAIL flow_control: occupancy after pop %0d, required < 2",
                             1 + issued - xfers - ((m_tvalid_o && m_tready_i) ? 1 : 0));
                end
                gotAddr.push_back(trace_mem_addr_o);
                issued++;
            end
            if (m_tvalid_o && m_tready_i) begin
                gotData.push_back(m_tdata_o);
                gotLast.push_back(m_tlast_o);
                xfers++;
                lastXferCycle = cycle;
            end
            if (done_o) begin
                if (doneSeen == 0) firstDoneCycle = cycle;
                doneSeen++;
            end
        end
    end

    task automatic clearMonitor();
        gotData.delete();
        gotLast.delete();
        gotAddr.delete();
        issued = 0;
        xfers = 0;
        doneSeen = 0;
        lastXferCycle = -1;
        firstDoneCycle = -1;
        monOn = 1'b1;
    endtask

    task automatic buildExpected(input logic [31:0] ptr, input logic [31:0] cnt);
        int n, first, row;
        logic [31:0] a;
        expData.delete();
        expLast.delete();
        expAddr.delete();
        n = (cnt > 32'(DEPTH)) ? DEPTH : int'(cnt);
        first = (int'(ptr % DEPTH) - n + DEPTH) % DEPTH;
        expData.push_back({80'b0, 16'(n), 16'(first), MAGIC});
        expLast.push_back(n == 0);
        for (int k = 0; k < 2 * n; k++) begin
            row = (first + k / 2) % DEPTH;
            a = BASE + 32'(row * 32 + (k % 2) * 16);
            expAddr.push_back(a);
            expData.push_back(memWord(a));
            expLast.push_back(k == 2 * n - 1);
        end
    endtask

    // Called at posedge+1; scrambles the snapshot inputs right after the start pulse.
    task automatic applyStimulus(input logic [31:0] ptr, input logic [31:0] cnt);
        trace_ptr_i = ptr;
        trace_count_i = cnt;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        trace_ptr_i = $urandom;
        trace_count_i = $urandom;
    endtask

    task automatic waitDone(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk_i); #1;
            if (doneSeen > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        #12;
        checks += 7;
        if (m_tvalid_o !== 1'b0)    begin errors++; $display("[TB] FAIL reset_tvalid got %b want 0", m_tvalid_o); end
        if (m_tlast_o !== 1'b0)     begin errors++; $display("[TB] FAIL reset_tlast got %b want 0", m_tlast_o); end
        if (m_tdata_o !== '0)       begin errors++; $display("[TB] FAIL reset_tdata got %h want 0", m_tdata_o); end
        if (trace_mem_en_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_en got %b want 0", trace_mem_en_o); end
        if (trace_mem_addr_o !== '0) begin errors++; $display("[TB] FAIL reset_addr got %h want 0", trace_mem_addr_o); end
        if (busy_o !== 1'b0)        begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy_o); end
        if (done_o !== 1'b0)        begin errors++; $display("[TB] FAIL reset_done got %b want 0", done_o); end
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (busy_o !== 1'b0 || m_tvalid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset busy %b tvalid %b want 0 0", busy_o, m_tvalid_o);
        end
    endtask

    task automatic test_full_dumps();
        scen_t scen[$];
        bit ok;
        scen.push_back('{32'd5, 32'd5, 1'b0});
        scen.push_back('{32'd3, 32'd1024, 1'b0});
        scen.push_back('{32'd9, 32'd0, 1'b0});
        scen.push_back('{32'd40, 32'd8, 1'b1});
        scen.push_back('{$urandom, 32'hFFFF_0000, 1'b0});
        for (int r = 0; r < 3; r++) scen.push_back('{$urandom, 32'($urandom_range(0, 1100)), 1'b1});
        foreach (scen[s]) begin
            clearMonitor();
            readyRandom = scen[s].rnd;
            buildExpected(scen[s].ptr, scen[s].cnt);
            applyStimulus(scen[s].ptr, scen[s].cnt);
            waitDone(10000, ok);
            checks++;
            if (!ok) begin errors++; $display("[TB] FAIL dump%0d_timeout done_o never seen", s); end
            checks++;
            if (gotData.size() !== expData.size()) begin
                errors++;
                $display("[TB] FAIL dump%0d_beat_count got %0d want %0d", s, gotData.size(), expData.size());
            end
            for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
                checks++;
                if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
                    errors++;
                    $display("[TB] FAIL dump%0d_beat%0d got %h/%b want %h/%b", s, i, gotData[i], gotLast[i], expData[i], expLast[i]);
                    break;
                end
            end
            checks++;
            if (gotAddr.size() !== expAddr.size()) begin
                errors++;
                $display("[TB] FAIL dump%0d_read_count got %0d want %0d", s, gotAddr.size(), expAddr.size());
            end
            for (int i = 0; i < gotAddr.size() && i < expAddr.size(); i++) begin
                checks++;
                if (gotAddr[i] !== expAddr[i]) begin
                    errors++;
                    $display("[TB] FAIL dump%0d_addr%0d got %h want %h", s, i, gotAddr[i], expAddr[i]);
                    break;
                end
            end
            checks += 3;
            if (doneSeen !== 1) begin errors++; $display("[TB] FAIL dump%0d_done_width got %0d want 1", s, doneSeen); end
            if (firstDoneCycle !== lastXferCycle + 1) begin
                errors++;
                $display("[TB] FAIL dump%0d_done_timing got cycle %0d want %0d", s, firstDoneCycle, lastXferCycle + 1);
            end
            if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL dump%0d_busy_end got %b want 0", s, busy_o); end
        end
        readyRandom = 1'b0;
    endtask

    task automatic test_abort();
        bit ok;
        int enBefore;
        clearMonitor();
        readyRandom = 1'b0;
        buildExpected(32'd20, 32'd8);
        applyStimulus(32'd20, 32'd8);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (xfers >= 4) begin ok = 1'b1; break; end
            @(posedge clk_i); #1;
        end
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL abort_wait_beats got %0d want 4", xfers); end
        abort_i = 1'b1;
        enBefore = issued;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        checks += 3;
        if (m_tvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_tvalid got %b want 0", m_tvalid_o); end
        if (done_o !== 1'b1)     begin errors++; $display("[TB] FAIL abort_done got %b want 1", done_o); end
        if (busy_o !== 1'b0)     begin errors++; $display("[TB] FAIL abort_busy got %b want 0", busy_o); end
        @(posedge clk_i); #1;
        checks += 3;
        if (done_o !== 1'b0)      begin errors++; $display("[TB] FAIL abort_done_width got %b want 0", done_o); end
        if (issued !== enBefore)  begin errors++; $display("[TB] FAIL abort_reads got %0d want %0d", issued, enBefore); end
        if (m_tvalid_o !== 1'b0)  begin errors++; $display("[TB] FAIL abort_tvalid_idle got %b want 0", m_tvalid_o); end
        for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
            checks++;
            if (gotData[i] !== expData[i] || gotLast[i] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_prefix%0d got %h/%b want %h/0", i, gotData[i], gotLast[i], expData[i]);
                break;
            end
        end
        clearMonitor();
        buildExpected(32'd1000, 32'd30);
        applyStimulus(32'd1000, 32'd30);
        waitDone(2000, ok);
        checks += 2;
        if (!ok) begin errors++; $display("[TB] FAIL restart_timeout done_o never seen"); end
        if (gotData.size() !== expData.size()) begin
            errors++;
            $display("[TB] FAIL restart_beat_count got %0d want %0d", gotData.size(), expData.size());
        end
        for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
            checks++;
            if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
                errors++;
                $display("[TB] FAIL restart_beat%0d got %h/%b want %h/%b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
                break;
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clearMonitor();
        readyRandom = 1'b1;
        buildExpected(32'd100, 32'd6);
        applyStimulus(32'd100, 32'd6);
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy_start got %b want 1", busy_o); end
        repeat (3) @(posedge clk_i);
        #1;
        start_i = 1'b1;
        trace_ptr_i = 32'd500;
        trace_count_i = 32'd77;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        waitDone(2000, ok);
        checks += 2;
        if (!ok) begin errors++; $display("[TB] FAIL b2b_first_timeout done_o never seen"); end
        if (gotData.size() !== expData.size()) begin
            errors++;
            $display("[TB] FAIL b2b_first_beat_count got %0d want %0d", gotData.size(), expData.size());
        end
        for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
            checks++;
            if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
                errors++;
                $display("[TB] FAIL b2b_first_beat%0d got %h/%b want %h/%b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
                break;
            end
        end
        clearMonitor();
        buildExpected(32'd2, 32'd9);
        applyStimulus(32'd2, 32'd9);
        waitDone(2000, ok);
        checks += 2;
        if (!ok) begin errors++; $display("[TB] FAIL b2b_second_timeout done_o never seen"); end
        if (gotAddr.size() !== expAddr.size()) begin
            errors++;
            $display("[TB] FAIL b2b_second_read_count got %0d want %0d", gotAddr.size(), expAddr.size());
        end
        for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
            checks++;
            if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
                errors++;
                $display("[TB] FAIL b2b_second_beat%0d got %h/%b want %h/%b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
                break;
            end
        end
        readyRandom = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        clearMonitor();
        readyRandom = 1'b0;
        buildExpected(32'd0, 32'd1024);
        applyStimulus(32'd0, 32'd1024);
        repeat (20) @(posedge clk_i);
        #1;
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL midreset_busy_before got %b want 1", busy_o); end
        #2;
        reset_n_i = 1'b0;
        #1;
        checks += 5;
        if (trace_mem_en_o !== 1'b0 || trace_mem_addr_o !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_read_port got %b/%h want 0/0", trace_mem_en_o, trace_mem_addr_o);
        end
        if (m_tvalid_o !== 1'b0 || m_tlast_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_stream_ctrl got %b/%b want 0/0", m_tvalid_o, m_tlast_o);
        end
        if (m_tdata_o !== '0) begin errors++; $display("[TB] FAIL midreset_tdata got %h want 0", m_tdata_o); end
        if (busy_o !== 1'b0)  begin errors++; $display("[TB] FAIL midreset_busy got %b want 0", busy_o); end
        if (done_o !== 1'b0)  begin errors++; $display("[TB] FAIL midreset_done got %b want 0", done_o); end
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        clearMonitor();
        readyRandom = 1'b1;
        buildExpected(32'd777, 32'd300);
        applyStimulus(32'd777, 32'd300);
        waitDone(4000, ok);
        checks += 2;
        if (!ok) begin errors++; $display("[TB] FAIL postreset_timeout done_o never seen"); end
        if (gotData.size() !== expData.size()) begin
            errors++;
            $display("[TB] FAIL postreset_beat_count got %0d want %0d", gotData.size(), expData.size());
        end
        for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
            checks++;
            if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
                errors++;
                $display("[TB] FAIL postreset_beat%0d got %h/%b want %h/%b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
                break;
            end
        end
        readyRandom = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_dumps();
        test_abort();
        test_back_to_back();
        test_reset_mid_read();
        monOn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
